// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with a post-reset init sweep.
// Latency: grant is combinational; read data returns one cycle after the accepting edge.
// Backpressure: readies stay low during the sweep; a loser holds its request until its ready is seen.
module sp_ram_arbiter #(
    parameter int unsigned         DEPTH    = 8,
    parameter int unsigned         WIDTH    = 8,
    parameter int unsigned         AW       = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]    INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_rdata,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_rdata,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_nxt;
    logic             ptr;
    logic             gnt_vld;
    logic             gnt_id;
    logic             win_we;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] hold0_q;
    logic [WIDTH-1:0] hold1_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        win_we    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        case (state)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = cnt;
                ram_wdata = INIT_VAL;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt_vld = req0_valid | req1_valid;
                // Pointer only breaks ties; a lone requester always wins.
                gnt_id  = (req0_valid && req1_valid) ? ptr : req1_valid;
                if (gnt_vld) begin
                    win_we    = gnt_id ? req1_we    : req0_we;
                    ram_we    = win_we;
                    ram_addr  = gnt_id ? req1_addr  : req0_addr;
                    ram_wdata = gnt_id ? req1_wdata : req0_wdata;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign req0_ready = gnt_vld && !gnt_id;
    assign req1_ready = gnt_vld &&  gnt_id;
    assign init_done  = (state == ST_RUN);

    // Read data passes straight through while valid and is held afterwards.
    assign rsp0_rdata = rsp0_valid ? ram_rdata : hold0_q;
    assign rsp1_rdata = rsp1_valid ? ram_rdata : hold1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            ptr        <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            if (gnt_vld) begin
                ptr <= ~gnt_id;
            end
            rsp0_valid <= gnt_vld && !gnt_id && !win_we;
            rsp1_valid <= gnt_vld &&  gnt_id && !win_we;
            if (rsp0_valid) begin
                hold0_q <= ram_rdata;
            end
            if (rsp1_valid) begin
                hold1_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_sp_ram_arbiter;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;
    localparam logic [WIDTH-1:0] INIT_VAL = 8'h00;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_wdata, rsp0_rdata;
    logic             req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_wdata, rsp1_rdata;
    logic             ram_we, init_done;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .init_done(init_done)
    );

    // Single-port RAM with registered, read-before-write output.
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep position, memory image, tie-break owner, and pending responses.
    int               m_sweep = 0;
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_ptr = 1'b0;
    logic             m_rv [2] = '{1'b0, 1'b0};
    logic [WIDTH-1:0] m_rd [2] = '{8'h00, 8'h00};
    logic [WIDTH-1:0] m_hold [2] = '{8'h00, 8'h00};
    logic             m_hk [2] = '{1'b0, 1'b0};
    logic [AW-1:0]    m_laddr = '0;
    logic [WIDTH-1:0] m_lwd = '0;

    always @(negedge clk) begin : cmp_blk
        logic             v [2];
        logic             we [2];
        logic [AW-1:0]    a [2];
        logic [WIDTH-1:0] d [2];
        logic             nv [2];
        logic [WIDTH-1:0] nd [2];
        logic             rv_act;
        logic [WIDTH-1:0] rd_act;
        int               g;
        if (!rst) begin
            chk_b("rst_ready0", req0_ready, 1'b0);
            chk_b("rst_ready1", req1_ready, 1'b0);
            chk_b("rst_rsp0_valid", rsp0_valid, 1'b0);
            chk_b("rst_rsp1_valid", rsp1_valid, 1'b0);
            chk_b("rst_init_done", init_done, 1'b0);
            m_sweep = 0;
            m_ptr   = 1'b0;
            m_rv    = '{1'b0, 1'b0};
            m_hk    = '{1'b0, 1'b0};
        end else begin
            v  = '{req0_valid, req1_valid};
            we = '{req0_we, req1_we};
            a  = '{req0_addr, req1_addr};
            d  = '{req0_wdata, req1_wdata};
            nv = '{1'b0, 1'b0};
            nd = '{8'h00, 8'h00};
            if (m_sweep < DEPTH) begin
                chk_b("sweep_ready0", req0_ready, 1'b0);
                chk_b("sweep_ready1", req1_ready, 1'b0);
                chk_b("sweep_we", ram_we, 1'b1);
                chk_w("sweep_addr", 32'(ram_addr), 32'(m_sweep));
                chk_w("sweep_wdata", 32'(ram_wdata), 32'(INIT_VAL));
                chk_b("sweep_init_done", init_done, 1'b0);
                m_mem[m_sweep] = INIT_VAL;
                m_laddr = AW'(m_sweep);
                m_lwd   = INIT_VAL;
                m_sweep++;
            end else begin
                chk_b("run_init_done", init_done, 1'b1);
                g = -1;
                if (v[0] && v[1]) g = int'(m_ptr);
                else if (v[0])    g = 0;
                else if (v[1])    g = 1;
                chk_b("ready0", req0_ready, g == 0);
                chk_b("ready1", req1_ready, g == 1);
                if (g >= 0) begin
                    chk_b("ram_we", ram_we, we[g]);
                    chk_w("ram_addr", 32'(ram_addr), 32'(a[g]));
                    chk_w("ram_wdata", 32'(ram_wdata), 32'(d[g]));
                    if (we[g]) m_mem[a[g]] = d[g];
                    else begin
                        nv[g] = 1'b1;
                        nd[g] = m_mem[a[g]];
                    end
                    m_laddr = a[g];
                    m_lwd   = d[g];
                    m_ptr   = (g == 0);
                end else begin
                    chk_b("idle_we", ram_we, 1'b0);
                    chk_w("idle_addr_hold", 32'(ram_addr), 32'(m_laddr));
                    chk_w("idle_wdata_hold", 32'(ram_wdata), 32'(m_lwd));
                end
            end
            for (int p = 0; p < 2; p++) begin
                rv_act = (p == 0) ? rsp0_valid : rsp1_valid;
                rd_act = (p == 0) ? rsp0_rdata : rsp1_rdata;
                chk_b(p == 0 ? "rsp0_valid" : "rsp1_valid", rv_act, m_rv[p]);
                if (m_rv[p]) begin
                    chk_w(p == 0 ? "rsp0_rdata" : "rsp1_rdata", 32'(rd_act), 32'(m_rd[p]));
                    m_hold[p] = m_rd[p];
                    m_hk[p]   = 1'b1;
                end else if (m_hk[p]) begin
                    chk_w(p == 0 ? "rsp0_hold" : "rsp1_hold", 32'(rd_act), 32'(m_hold[p]));
                end
            end
            m_rv = nv;
            m_rd = nd;
        end
    end

    task automatic drive(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int p, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        output logic [WIDTH-1:0] rd);
        logic ok;
        ok = 1'b0;
        drive(p, 1'b1, we, a, d);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk_b("xfer_grant", ok, 1'b1);
        tick();
        drive(p, 1'b0, we, a, d);
        rd = '0;
        if (!we) begin
            @(negedge clk);
            chk_b("xfer_rsp_valid", (p == 0) ? rsp0_valid : rsp1_valid, 1'b1);
            rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
            tick();
        end
    endtask

    task automatic wait_sweep;
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (init_done) break;
            n++;
        end
        chk_w("sweep_cycles", 32'(n), 32'd8);
        tick();
    endtask

    initial begin : stim
        logic [WIDTH-1:0] rd;
        logic acc0, acc1;
        drive(0, 1'b1, 1'b0, 3'd0, 8'h00);
        drive(1, 1'b1, 1'b0, 3'd1, 8'h00);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        wait_sweep();
        drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 3'd0, 8'h00);

        // req0 streams writes then reads, req1 idle
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b1, AW'(i), 8'(8'h10 + i));
            @(negedge clk);
            chk_b("wr_stream_ready0", req0_ready, 1'b1);
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(0, 1'b1, 1'b0, AW'(i), 8'h00);
            else       drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
            @(negedge clk);
            if (i < 8) chk_b("rd_stream_ready0", req0_ready, 1'b1);
            if (i > 0) begin
                chk_b("rd_stream_rsp0_valid", rsp0_valid, 1'b1);
                chk_w("rd_stream_rdata", 32'(rsp0_rdata), 32'h10 + 32'(i - 1));
            end
            tick();
        end

        // req1 alone three times, then both contend
        drive(1, 1'b1, 1'b0, 3'd5, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_b("solo_ready1", req1_ready, 1'b1);
            tick();
        end
        drive(0, 1'b1, 1'b0, 3'd3, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk_b("contend_ready0", req0_ready, (k % 2) == 0);
                chk_b("contend_ready1", req1_ready, (k % 2) == 1);
            end
            if (k > 0) begin
                if (((k - 1) % 2) == 0) chk_w("contend_rsp0", 32'(rsp0_rdata), 32'h13);
                else                    chk_w("contend_rsp1", 32'(rsp1_rdata), 32'h15);
            end
            tick();
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
                drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
            end
        end

        xfer(0, 1'b1, 3'd2, 8'hAA, rd);
        xfer(0, 1'b0, 3'd2, 8'h00, rd);
        chk_w("wr_then_rd_aa", 32'(rd), 32'hAA);

        // read then same-address write on the next cycle returns old data
        drive(0, 1'b1, 1'b0, 3'd4, 8'h00);
        @(negedge clk);
        chk_b("rbw_rd_ready", req0_ready, 1'b1);
        tick();
        drive(0, 1'b1, 1'b1, 3'd4, 8'h55);
        @(negedge clk);
        chk_b("rbw_wr_ready", req0_ready, 1'b1);
        chk_b("rbw_rsp_valid", rsp0_valid, 1'b1);
        chk_w("rbw_old_data", 32'(rsp0_rdata), 32'h14);
        tick();
        drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
        xfer(1, 1'b0, 3'd4, 8'h00, rd);
        chk_w("rbw_new_data", 32'(rd), 32'h55);

        // reset right after a read is accepted
        drive(1, 1'b1, 1'b0, 3'd1, 8'h00);
        @(negedge clk);
        chk_b("pre_rst_ready1", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_b("midrst_rsp1_valid", rsp1_valid, 1'b0);
        chk_b("midrst_init_done", init_done, 1'b0);
        chk_b("midrst_ready1", req1_ready, 1'b0);
        drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        wait_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            xfer(i % 2, 1'b0, AW'(i), 8'h00, rd);
            chk_w("resweep_word", 32'(rd), 32'(INIT_VAL));
        end

        // random traffic honouring the hold-until-ready obligation
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (!req0_valid || acc0)
                drive(0, $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
            if (!req1_valid || acc1)
                drive(1, $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
        end
        drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one single-port RAM (one access per clock: write or read, registered read data with 1-cycle latency) between two requesters using round-robin arbitration.
- After reset, a sweep FSM first writes INIT_VAL to every RAM location. Only then does it start accepting requests.
- Sits between two client blocks and the RAM instance. Drives the RAM we/addr/data_in pins and consumes its data_out.

Parameters:
- DEPTH, 8, number of RAM words. Power of two, >= 2.
- WIDTH, 8, data word width in bits.
- AW, $clog2(DEPTH), address width. Derived; do not override.
- INIT_VAL, 0, WIDTH-bit value written to every word during the init sweep.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an access pending.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  AW  access address.
- req0_wdata  in  WIDTH  write data.
- req0_ready  out  1  requester 0 granted this cycle.
- rsp0_valid  out  1  read data for requester 0 is valid.
- rsp0_rdata  out  WIDTH  read data for requester 0.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as above, for requester 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_rdata  in  WIDTH  RAM registered read data.
- init_done  out  1  high once the init sweep has completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, sweep counter=0, priority pointer=0.
  - rsp0_valid=0, rsp1_valid=0, init_done=0.
  - Both readies are 0.
- FSM has two states, INIT and RUN.
- INIT:
  - ram_we=1, ram_addr=counter, ram_wdata=INIT_VAL.
  - Counter increments every cycle.
  - At the edge where counter==DEPTH-1: go to RUN, set init_done=1, counter wraps to 0.
  - The sweep therefore takes exactly DEPTH cycles after reset release.
  - Both readies are 0 throughout; incoming valids are ignored and must be held by the requesters.
- RUN, grant logic (combinational):
  - Only req0_valid=1: grant 0.
  - Only req1_valid=1: grant 1.
  - Both valid: grant the requester selected by the priority pointer.
  - Neither valid: no grant.
  - reqN_ready = (grant==N). At most one ready is high in any cycle.
  - A transfer happens on any edge where valid&&ready.
- RUN, RAM drive (combinational from the winner):
  - ram_we = winner_we, ram_addr = winner_addr, ram_wdata = winner_wdata.
  - With no winner: ram_we=0 and addr/wdata hold their last values.
- Priority pointer:
  - On every transfer the pointer becomes (winner ^ 1).
  - With no transfer the pointer is unchanged.
- Read response:
  - The edge that accepts a read sets rspN_valid=1 for exactly one cycle, to the original requester.
  - In that cycle rspN_rdata = ram_rdata.
  - Writes produce no response.
  - rspN_rdata is registered-through: it holds its value when rspN_valid=0.
- Back-to-back operation:
  - One transfer per cycle is sustained.
  - A read followed by a write to the same address in the next cycle returns the old data, per the RAM's read-before-write behaviour.
- Requester obligations:
  - Hold valid/we/addr/wdata stable until ready is seen.
  - The arbiter does not retract a grant while the valid is held.
- Reset mid-operation: any pending rsp_valid is dropped and the full init sweep restarts.

Test Plan:
- Release reset with DEPTH=8 and both valids high -> readies stay 0 for 8 cycles, ram_addr steps 0..7 with ram_we=1, then init_done=1 on the 8th edge.
- After init, req0 writes addr i with data i+8'h10 for i=0..7, req1 idle -> 8 consecutive readies on port 0; then req0 reads 0..7 -> rsp0_valid each cycle with data 10..17 in order, and rsp1_valid never asserts.
- Both request continuously (req0 read addr 3, req1 read addr 5), pointer=0 -> grants alternate 0,1,0,1; rsp0_rdata=13 and rsp1_rdata=15, each one cycle after its grant.
- req1 alone for 3 transfers, then both valid -> first contested grant goes to req0 (pointer=0 after each req1 transfer).
- Write addr 2 = 8'hAA, then read addr 2 -> rsp returns AA. Read addr 4 with a same-cycle-next write of 8'h55 to addr 4 -> read returns 14.
- Assert rst low mid-run with a read just accepted -> rsp_valid=0 immediately, init_done=0, and a re-sweep writes INIT_VAL to all 8 words (a read of addr 0 afterwards returns 00).
